intra_nbr_ctx: RTL and testbench
================================

Name: intra_nbr_ctx

Overview:
- Neighbour-context stage for luma 16x16 intra mode decision.
- Sits directly upstream of the intra mode picker and supplies its top, left and top_left predictor samples for macroblock (x,y).
- Also consumes the picker's reconstructed 16x16 output block. From that block it stores the bottom row in a top-line buffer and the right column in a left register, ready for later macroblocks.
- Applies the frame-edge fill rules: 127 on the top edge, 129 on the left edge.

Parameters:
- BLOCK_SIZE, 16, macroblock edge length in pixels.
- MAX_MB_W, 256, maximum frame width in macroblocks; sets the top-line buffer depth.
- AW, 8, top-line buffer address width; must satisfy 2^AW >= MAX_MB_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mb_w  in  10  frame width in macroblocks; held stable for the whole frame.
- fetch_start  in  1  one-cycle request for the neighbours of (x,y).
- x  in  10  macroblock column, sampled with fetch_start or upd_start.
- y  in  10  macroblock row, sampled with fetch_start or upd_start.
- upd_start  in  1  one-cycle request to store the reconstruction of (x,y).
- recon  in  8*BLOCK_SIZE*BLOCK_SIZE  reconstructed block, raster order, pixel 0 in LSBs; sampled with upd_start.
- top  out  8*BLOCK_SIZE  row above the macroblock; byte i = column i.
- left  out  8*BLOCK_SIZE  column left of the macroblock; byte j = row j.
- top_left  out  8  corner pixel.
- fetch_done  out  1  one-cycle pulse; top, left and top_left are valid and held until the next fetch_done.
- upd_done  out  1  one-cycle pulse; the store has completed.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: synchronous and active-high. All outputs return to 0, the state returns to IDLE, the pending flag clears, and the left and corner registers clear. Buffer RAM contents are not cleared; edge rules make this safe. A reset taken mid-operation aborts it with no done pulse.
- States:
  - IDLE: if upd_start, go to WR. Else if fetch_start or pend, go to RD.
  - RD: drive the RAM address from the latched x; go to OUT.
  - OUT: register the outputs and pulse fetch_done; go to IDLE.
  - WR: write the RAM and registers and pulse upd_done; go to IDLE.
- Latency:
  - fetch_done rises exactly 2 cycles after fetch_start is sampled.
  - upd_done rises 1 cycle after upd_start is sampled.
  - Add 1 cycle when a fetch was deferred.
- Simultaneous fetch_start and upd_start in IDLE: the update is served first. The fetch's x and y are latched and pend is set. RD is entered on the cycle after WR.
- A request arriving while busy=1 is ignored. The exception is a fetch arriving in the WR state, which is latched into pend.
- Edge rules for fetch(x,y):
  - y==0: top = all 127 and top_left = 127, regardless of x.
  - x==0: left = all 129.
  - x==0 and y>0: top_left = 129.
  - Otherwise: top = buf[x], left = left_reg, top_left = tl_reg.
- Update(x,y) actions:
  - buf[x] <= recon row 15.
  - left_reg <= recon column 15.
  - tl_reg <= byte 15 of the top most recently output by fetch(x,y); if y==0, tl_reg <= 127.
- Ordering contract: the sequence is fetch(x,y) then update(x,y), in raster order, before fetch of the next macroblock. Other orders give undefined data but must not hang the block.
- x >= mb_w or x >= MAX_MB_W: fetch returns edge fill (all 127, top_left 127) and update writes nothing. Both done pulses still occur.
- RAM is single-port, one 8*BLOCK_SIZE-bit word per column, with registered read.

Optional Feature:
- Macro: INTRA_NBR_TOP_RIGHT_EN.
- When defined:
  - Adds output port top_right [31:0], valid with fetch_done.
  - Value is bytes 0..3 of buf[x+1].
  - If x+1 == mb_w, the value is byte 15 of top replicated 4 times.
  - If y==0, the value is all 127.
  - Adds one RD2 state; fetch latency becomes 3 cycles.
- When undefined: no top_right port and 2-cycle fetch latency.

Decomposition:
- Shared package contents:
  - Edge constants: EDGE_TOP=8'd127, EDGE_LEFT=8'd129.
  - BLOCK_SIZE.
  - The state encoding, one-hot 4 bits: IDLE=1, RD=2, OUT=4, WR=8, and RD2=16 when the feature is enabled.
- One sub-module, intra_nbr_linebuf: a single-port RAM with write enable and registered read.

Test Plan:
- Reset, then fetch(0,0) -> fetch_done at +2 cycles; top all 8'h7F, left all 8'h81, top_left 8'h7F.
- mb_w=2:
  - Update(0,0) with recon pixel value = row*16+col.
  - Then fetch(1,0) -> left byte j = j*16+15; top all 127; top_left 127.
  - Then, after update(1,0), fetch(0,1) -> top byte i = 240+i; left all 129; top_left 129.
- Continue the previous case with update(0,1) then fetch(1,1) -> top = row 15 of block (1,0); top_left = 255 (byte 15 of the top fetched for (0,1)).
- fetch_start and upd_start asserted in the same cycle -> upd_done at +1 and fetch_done at +3. The fetched data reflects the completed update.
- upd_start with x=mb_w=2 -> upd_done pulses and buf is unchanged. Assert rst during RD -> no fetch_done, all outputs 0 on the next cycle.
- With INTRA_NBR_TOP_RIGHT_EN defined, fetch(1,1) with mb_w=2 -> top_right = {4{top[127:120]}} at +3 cycles.

Source files
------------

// File: rtl/intra_nbr_ctx_pkg.sv
// Shared definitions for the intra 16x16 neighbour-context stage.
// Holds the frame-edge fill values, the block edge length, the one-hot
// controller state encoding and a small row-fill helper.
// Optional feature macro: INTRA_NBR_TOP_RIGHT_EN (adds the RD2 state).
package intra_nbr_ctx_pkg;

  localparam int unsigned BLOCK_SIZE = 16;
  localparam logic [7:0]  EDGE_TOP   = 8'd127;
  localparam logic [7:0]  EDGE_LEFT  = 8'd129;

`ifdef INTRA_NBR_TOP_RIGHT_EN
  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    RD   = 5'b00010,
    OUT  = 5'b00100,
    WR   = 5'b01000,
    RD2  = 5'b10000
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    RD   = 4'b0010,
    OUT  = 4'b0100,
    WR   = 4'b1000
  } state_t;
`endif

  function automatic logic [8*BLOCK_SIZE-1:0] fill_row(input logic [7:0] v);
    return {BLOCK_SIZE{v}};
  endfunction

endpackage

// File: rtl/intra_nbr_linebuf.sv
// Top-line buffer: single-port RAM, one word per macroblock column, with
// write enable and registered read (read-during-write returns old data).
// Ports: clk; we write enable; addr word address; wdata write word;
//        rdata registered read word.
module intra_nbr_linebuf #(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/intra_nbr_ctx.sv
// Neighbour-context stage for luma 16x16 intra mode decision.
// Supplies top / left / top_left predictor samples for macroblock (x,y) and
// stores the bottom row / right column of each reconstructed block for the
// macroblocks that follow. Frame edges are filled with 127 (top) / 129 (left).
// Ports: clk, rst (sync, active-high); mb_w frame width in MBs;
//        fetch_start / upd_start one-cycle requests with x, y (and recon);
//        top, left, top_left neighbour outputs, valid with fetch_done;
//        fetch_done / upd_done completion pulses; busy = state not IDLE.
// Optional feature macro: INTRA_NBR_TOP_RIGHT_EN adds top_right[31:0]
// (bytes 0..3 of the column to the right) and one extra fetch cycle.
module intra_nbr_ctx
  import intra_nbr_ctx_pkg::*;
#(
  parameter int unsigned MAX_MB_W = 256,
  parameter int unsigned AW       = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [9:0]                          mb_w,
  input  logic                                fetch_start,
  input  logic [9:0]                          x,
  input  logic [9:0]                          y,
  input  logic                                upd_start,
  input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]  recon,
  output logic [8*BLOCK_SIZE-1:0]             top,
  output logic [8*BLOCK_SIZE-1:0]             left,
  output logic [7:0]                          top_left,
`ifdef INTRA_NBR_TOP_RIGHT_EN
  output logic [31:0]                         top_right,
`endif
  output logic                                fetch_done,
  output logic                                upd_done,
  output logic                                busy
);

  localparam int unsigned BW    = 8*BLOCK_SIZE;
  localparam logic [10:0] MAX_W = 11'(MAX_MB_W);

  state_t          state;
  logic            pend;
  logic [9:0]      fx, fy, up_x, up_y;
  logic [BW-1:0]   up_row, up_col;
  logic [BW-1:0]   left_reg;
  logic [7:0]      tl_reg;
  logic [BW-1:0]   rc_row, rc_col;
  logic [BW-1:0]   rdata, top_word;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic            fetch_oob, upd_oob;

  // Only row 15 and column 15 of the block are kept; the rest of recon is
  // folded here so it is visibly consumed.
  logic            unused_recon;
  assign unused_recon = ^recon;

  assign rc_row = recon[BW*(BLOCK_SIZE-1) +: BW];

  always_comb begin
    rc_col = '0;
    for (int unsigned j = 0; j < BLOCK_SIZE; j++)
      rc_col[8*j +: 8] = recon[8*(j*BLOCK_SIZE + BLOCK_SIZE - 1) +: 8];
  end

  assign fetch_oob = (fx >= mb_w)   || ({1'b0, fx}   >= MAX_W);
  assign upd_oob   = (up_x >= mb_w) || ({1'b0, up_x} >= MAX_W);
  assign busy      = (state != IDLE);

`ifdef INTRA_NBR_TOP_RIGHT_EN
  logic [9:0]    fx_next;
  logic [BW-1:0] top_hold;
  assign fx_next  = fx + 10'd1;
  // RD2 re-points the RAM at x+1, so buf[x] is parked in top_hold.
  assign top_word = top_hold;
`else
  assign top_word = rdata;
`endif

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = fx[AW-1:0];
    if (state == WR) begin
      ram_we   = !upd_oob;
      ram_addr = up_x[AW-1:0];
    end
`ifdef INTRA_NBR_TOP_RIGHT_EN
    if (state == RD2) ram_addr = fx_next[AW-1:0];
`endif
  end

  intra_nbr_linebuf #(
    .W     (BW),
    .DEPTH (MAX_MB_W),
    .AW    (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (up_row),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= 1'b0;
      left_reg   <= '0;
      tl_reg     <= '0;
      top        <= '0;
      left       <= '0;
      top_left   <= '0;
      fetch_done <= 1'b0;
      upd_done   <= 1'b0;
`ifdef INTRA_NBR_TOP_RIGHT_EN
      top_right  <= '0;
`endif
    end else begin
      fetch_done <= 1'b0;
      upd_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (upd_start) begin
            state  <= WR;
            up_x   <= x;
            up_y   <= y;
            up_row <= rc_row;
            up_col <= rc_col;
            if (fetch_start) begin
              pend <= 1'b1;
              fx   <= x;
              fy   <= y;
            end
          end else if (fetch_start) begin
            state <= RD;
            fx    <= x;
            fy    <= y;
          end else if (pend) begin
            state <= RD;
            pend  <= 1'b0;
          end
        end
        RD: begin
`ifdef INTRA_NBR_TOP_RIGHT_EN
          state <= RD2;
`else
          state <= OUT;
`endif
        end
`ifdef INTRA_NBR_TOP_RIGHT_EN
        RD2: begin
          top_hold <= rdata;
          state    <= OUT;
        end
`endif
        OUT: begin
          fetch_done <= 1'b1;
          state      <= IDLE;
          if (fetch_oob) begin
            top      <= fill_row(EDGE_TOP);
            left     <= fill_row(EDGE_TOP);
            top_left <= EDGE_TOP;
`ifdef INTRA_NBR_TOP_RIGHT_EN
            top_right <= {4{EDGE_TOP}};
`endif
          end else begin
            top      <= (fy == '0) ? fill_row(EDGE_TOP) : top_word;
            left     <= (fx == '0) ? fill_row(EDGE_LEFT) : left_reg;
            top_left <= (fy == '0) ? EDGE_TOP : ((fx == '0) ? EDGE_LEFT : tl_reg);
`ifdef INTRA_NBR_TOP_RIGHT_EN
            if (fy == '0)
              top_right <= {4{EDGE_TOP}};
            else if (fx_next == mb_w)
              top_right <= {4{top_word[BW-1 -: 8]}};
            else
              top_right <= rdata[31:0];
`endif
          end
        end
        WR: begin
          upd_done <= 1'b1;
          if (!upd_oob) begin
            left_reg <= up_col;
            tl_reg   <= (up_y == '0) ? EDGE_TOP : top[BW-1 -: 8];
          end
          // A fetch deferred behind (or arriving during) the update goes
          // straight to RD so it sees the freshly written column.
          if (fetch_start || pend) begin
            if (fetch_start) begin
              fx <= x;
              fy <= y;
            end
            pend  <= 1'b0;
            state <= RD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intra_nbr_ctx.sv
// Scoreboard bench for intra_nbr_ctx: stimulus pushes expected done cycles
// and neighbour data; a negedge monitor checks every done pulse against them.
module tb_intra_nbr_ctx;
  import intra_nbr_ctx_pkg::*;

  localparam int unsigned BW = 8*BLOCK_SIZE;
  localparam int unsigned RW = 8*BLOCK_SIZE*BLOCK_SIZE;
`ifdef INTRA_NBR_TOP_RIGHT_EN
  localparam int unsigned FL = 3;
`else
  localparam int unsigned FL = 2;
`endif

  typedef struct {
    int unsigned cyc;
    logic [BW-1:0] top;
    logic [BW-1:0] left;
    logic [7:0]    tl;
    logic [31:0]   tr;
  } fexp_t;

  logic          clk, rst, fetch_start, upd_start;
  logic [9:0]    mb_w, x, y;
  logic [RW-1:0] recon;
  logic [BW-1:0] top, left;
  logic [7:0]    top_left;
  logic          fetch_done, upd_done, busy;
`ifdef INTRA_NBR_TOP_RIGHT_EN
  logic [31:0]   top_right;
`endif

  intra_nbr_ctx #(.MAX_MB_W(256), .AW(8)) dut (
    .clk(clk), .rst(rst), .mb_w(mb_w), .fetch_start(fetch_start),
    .x(x), .y(y), .upd_start(upd_start), .recon(recon),
    .top(top), .left(left), .top_left(top_left),
`ifdef INTRA_NBR_TOP_RIGHT_EN
    .top_right(top_right),
`endif
    .fetch_done(fetch_done), .upd_done(upd_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fexp_t       fetch_q[$];
  int unsigned upd_q[$];
  int unsigned f_rd = 0, u_rd = 0;
  int unsigned checks = 0, errors = 0;
  int unsigned zc = 32'hFFFF_FFFF;

  function automatic logic [BW-1:0] rep(input logic [7:0] v);
    return {BLOCK_SIZE{v}};
  endfunction

  function automatic logic [RW-1:0] blk(input logic [7:0] k);
    logic [RW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BLOCK_SIZE*BLOCK_SIZE; i++) r[8*i +: 8] = 8'(i) ^ k;
    return r;
  endfunction

  function automatic logic [BW-1:0] row15(input logic [7:0] k);
    logic [BW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BLOCK_SIZE; i++) r[8*i +: 8] = 8'(BLOCK_SIZE*(BLOCK_SIZE-1) + i) ^ k;
    return r;
  endfunction

  function automatic logic [BW-1:0] col15(input logic [7:0] k);
    logic [BW-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < BLOCK_SIZE; j++) r[8*j +: 8] = 8'(j*BLOCK_SIZE + BLOCK_SIZE - 1) ^ k;
    return r;
  endfunction

  function automatic fexp_t mk(input logic [BW-1:0] t, input logic [BW-1:0] l,
                               input logic [7:0] tl, input logic [31:0] tr);
    fexp_t e;
    e.cyc = 0; e.top = t; e.left = l; e.tl = tl; e.tr = tr;
    return e;
  endfunction

  task automatic ck(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: zero check after reset, overdue expectations, done-pulse compares.
  always @(negedge clk) begin
    if (cyc == zc) begin
      ck("rst_top", top, '0);
      ck("rst_left", left, '0);
      ck("rst_top_left", BW'(top_left), '0);
      ck("rst_fetch_done", BW'(fetch_done), '0);
      ck("rst_upd_done", BW'(upd_done), '0);
      ck("rst_busy", BW'(busy), '0);
`ifdef INTRA_NBR_TOP_RIGHT_EN
      ck("rst_top_right", BW'(top_right), '0);
`endif
    end
    if (u_rd < upd_q.size() && upd_q[u_rd] < cyc) begin
      checks++; errors++;
      $display("FAIL upd_timeout: no upd_done, expected at cycle %0d, now %0d", upd_q[u_rd], cyc);
      u_rd++;
    end
    if (f_rd < fetch_q.size() && fetch_q[f_rd].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: no fetch_done, expected at cycle %0d, now %0d", fetch_q[f_rd].cyc, cyc);
      f_rd++;
    end
    if (upd_done) begin
      if (u_rd < upd_q.size()) begin
        ck("upd_cycle", BW'(cyc), BW'(upd_q[u_rd]));
        u_rd++;
      end else begin
        checks++; errors++;
        $display("FAIL upd_unexpected: upd_done at cycle %0d, none expected", cyc);
      end
    end
    if (fetch_done) begin
      if (f_rd < fetch_q.size()) begin
        ck("fetch_cycle", BW'(cyc), BW'(fetch_q[f_rd].cyc));
        ck("top", top, fetch_q[f_rd].top);
        ck("left", left, fetch_q[f_rd].left);
        ck("top_left", BW'(top_left), BW'(fetch_q[f_rd].tl));
`ifdef INTRA_NBR_TOP_RIGHT_EN
        ck("top_right", BW'(top_right), BW'(fetch_q[f_rd].tr));
`endif
        f_rd++;
      end else begin
        checks++; errors++;
        $display("FAIL fetch_unexpected: fetch_done at cycle %0d, none expected", cyc);
      end
    end
  end

  task automatic req(input logic f, input logic u, input logic [9:0] xx, input logic [9:0] yy,
                     input logic [RW-1:0] rc, input fexp_t fe);
    fexp_t e;
    @(negedge clk);
    fetch_start = f; upd_start = u; x = xx; y = yy; recon = rc;
    if (u) upd_q.push_back(cyc + 2);
    if (f) begin
      e = fe;
      e.cyc = cyc + 1 + FL + (u ? 1 : 0);
      fetch_q.push_back(e);
    end
    @(negedge clk);
    fetch_start = 1'b0; upd_start = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  logic [BW-1:0] r0, rb, rd;
  logic [31:0]   e127;

  initial begin
    rst = 1'b1; fetch_start = 1'b0; upd_start = 1'b0;
    x = '0; y = '0; mb_w = 10'd2; recon = '0;
    r0 = row15(8'h00); rb = row15(8'hA5); rd = row15(8'h11);
    e127 = {4{8'd127}};
    repeat (3) @(negedge clk);
    zc = cyc + 1;
    @(negedge clk);
    rst = 1'b0;

    // frame start, then raster walk over a 2-MB-wide frame
    req(1, 0, 0, 0, '0,          mk(rep(8'd127), rep(8'd129), 8'd127, e127));
    req(0, 1, 0, 0, blk(8'h00),  mk('0, '0, '0, '0));
    req(1, 0, 1, 0, '0,          mk(rep(8'd127), col15(8'h00), 8'd127, e127));
    req(0, 1, 1, 0, blk(8'hA5),  mk('0, '0, '0, '0));
    req(1, 0, 0, 1, '0,          mk(r0, rep(8'd129), 8'd129, rb[31:0]));
    req(0, 1, 0, 1, blk(8'h3C),  mk('0, '0, '0, '0));
    req(1, 0, 1, 1, '0,          mk(rb, col15(8'h3C), 8'hFF, {4{rb[BW-1 -: 8]}}));
    // column beyond the frame width: all edge fill
    req(1, 0, 2, 1, '0,          mk(rep(8'd127), rep(8'd127), 8'd127, e127));
    // simultaneous request: update first, fetch sees the new bottom row
    req(1, 1, 0, 2, blk(8'h11),  mk(rd, rep(8'd129), 8'd129, rb[31:0]));
    req(1, 0, 0, 2, '0,          mk(rd, rep(8'd129), 8'd129, rb[31:0]));
    req(0, 1, 0, 2, blk(8'h11),  mk('0, '0, '0, '0));
    // out-of-frame update must leave left/corner state alone
    req(0, 1, 2, 2, {(RW/8){8'h66}}, mk('0, '0, '0, '0));
    req(1, 0, 1, 2, '0,          mk(rb, col15(8'h11), rd[BW-1 -: 8], {4{rb[BW-1 -: 8]}}));

    // reset while in RD: no fetch_done, outputs cleared
    @(negedge clk);
    fetch_start = 1'b1; x = 10'd1; y = 10'd1;
    @(negedge clk);
    fetch_start = 1'b0; rst = 1'b1; zc = cyc + 1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    req(1, 0, 0, 0, '0,          mk(rep(8'd127), rep(8'd129), 8'd127, e127));

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
